// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
// Optional feature macro: FETCH_TIMEOUT_EN (see fetch_unit.sv).
package fetch_unit_pkg;

    localparam logic [5:0] OP_J       = 6'h10;
    localparam logic [5:0] OP_JR      = 6'h11;
    localparam logic [5:0] OP_BR_BASE = 6'h18;
    localparam logic [5:0] OP_HALT    = 6'h3F;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_J   = 2'd1;
    localparam logic [1:0] PCSEL_JR  = 2'd2;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_FETCH = 2'd1;
    localparam state_t S_HOLD  = 2'd2;
    localparam state_t S_HALT  = 2'd3;

endpackage

// File: rtl/fetch_unit_instr_decode.sv
// Combinational decode of the held instruction word into
// next-address control fields.
module instr_decode
    import fetch_unit_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [1:0]  pc_sel_o,
    output logic [2:0]  brtype_o,
    output logic [15:0] branch_label_o,
    output logic [25:0] jmp_label_o
);

    logic [5:0] op;

    assign op             = instr_i[31:26];
    assign branch_label_o = instr_i[15:0];
    assign jmp_label_o    = instr_i[25:0];

    // Branches occupy 0x19..0x1F; 0x18 itself is not a branch.
    always_comb begin
        pc_sel_o = PCSEL_SEQ;
        brtype_o = 3'd0;
        unique case (1'b1)
            (op == OP_J):  pc_sel_o = PCSEL_J;
            (op == OP_JR): pc_sel_o = PCSEL_JR;
            (op[5:3] == OP_BR_BASE[5:3] && op[2:0] != 3'd0):
                brtype_o = op[2:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: IDLE -> FETCH -> HOLD -> FETCH ... or HALT.
// Define FETCH_TIMEOUT_EN to add the fetch_err watchdog.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [1:0]  pc_sel,
    output logic [2:0]  brtype,
    output logic [15:0] branch_label,
    output logic [25:0] jmp_label,
    output logic        halted
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic        fetch_err
`endif
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // HALT is accepted like any instruction but freezes pc.
                if (instr_ready) begin
                    if (instr_q[31:26] == OP_HALT) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;

    // Request stays up on timeout; only the wait counter restarts.
    always_comb begin
        cnt_d     = '0;
        fetch_err = 1'b0;
        if (state_q == S_FETCH && !imem_ack) begin
            if (cnt_q == 4'hF) begin
                fetch_err = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr_valid = (state_q == S_HOLD);
    assign halted      = (state_q == S_HALT);

    instr_decode u_dec (
        .instr_i        (instr_q),
        .pc_sel_o       (pc_sel),
        .brtype_o       (brtype),
        .branch_label_o (branch_label),
        .jmp_label_o    (jmp_label)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed and randomized fetches
// checked against a transaction-level model of pc and decode rules.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  pc_sel;
    logic [2:0]  brtype;
    logic [15:0] branch_label;
    logic [25:0] jmp_label;
    logic        halted;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .next_pc      (next_pc),
        .pc           (pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_sel       (pc_sel),
        .brtype       (brtype),
        .branch_label (branch_label),
        .jmp_label    (jmp_label),
        .halted       (halted)
`ifdef FETCH_TIMEOUT_EN
        ,
        .fetch_err    (fetch_err)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_pcsel(input int op);
        if (op == 16) return 2'd1;
        if (op == 17) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [2:0] ref_brtype(input int op);
        if (op >= 25 && op <= 31) return 3'(op % 8);
        return 3'd0;
    endfunction

    task automatic chk_fields(input string tag, input logic [31:0] w);
        int op;
        op = int'(w >> 26);
        chk({tag, "_pc_sel"}, pc_sel, ref_pcsel(op));
        chk({tag, "_brtype"}, brtype, ref_brtype(op));
        chk({tag, "_blabel"}, branch_label, w & 32'h0000_FFFF);
        chk({tag, "_jlabel"}, jmp_label, w & 32'h03FF_FFFF);
    endtask

    // One full memory transaction plus downstream accept.
    task automatic fetch_one(input logic [31:0] w, input int lat,
                             input int stall, input logic [31:0] np);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk("req_seen", imem_req, 1);
        chk("addr", imem_addr, model_pc);
        for (int i = 0; i < lat; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            step();
            chk("wait_req", imem_req, 1);
            chk("wait_valid", instr_valid, 0);
            chk("wait_addr", imem_addr, model_pc);
        end
        instr_ready = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = w;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("valid", instr_valid, 1);
        chk("req_drop", imem_req, 0);
        chk("not_halted", halted, 0);
        chk_fields("dec", w);
        for (int i = 0; i < stall; i++) begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            next_pc    = $urandom;
            step();
            chk("stall_valid", instr_valid, 1);
            chk("stall_pc", pc, model_pc);
            chk_fields("stall", w);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        next_pc     = np;
        step();
        instr_ready = 1'b0;
        next_pc     = $urandom;
        if (w[31:26] == 6'h3F) begin
            chk("halt_flag", halted, 1);
            chk("halt_pc", pc, model_pc);
        end else begin
            model_pc = np;
            chk("acc_pc", pc, model_pc);
            chk("acc_valid", instr_valid, 0);
            chk("acc_req", imem_req, 1);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        int          pulses;
        int          prev;
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        next_pc     = '0;
        instr_ready = 1'b0;
        model_pc    = '0;
        repeat (3) step();

        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_halted", halted, 0);
        chk_fields("rst", 32'h0);

        rst_n = 1'b1;
        chk("idle_req", imem_req, 0);
        step();
        chk("fetch_req", imem_req, 1);

        fetch_one(32'h0000_0000, 2, 0, 32'd4);
        fetch_one(32'h4000_001A, 1, 0, 32'd26);
        fetch_one(32'h6400_0047, 0, 3, 32'd30);
        fetch_one(32'h4400_1234, 0, 1, 32'hFFFF_FFFC);
        fetch_one(32'h7C00_BEEF, 1, 0, 32'h0000_0000);
        fetch_one(32'h6000_0001, 0, 0, 32'h0000_0100);

        for (int k = 0; k < 25; k++) begin
            w = {6'($urandom_range(0, 62)), 26'($urandom)};
            fetch_one(w, $urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom);
        end

        // Reset during FETCH; an ack right after release must be dropped.
        step();
        chk("mid_req", imem_req, 1);
        rst_n = 1'b0;
        #1;
        model_pc = '0;
        chk("arst_req", imem_req, 0);
        chk("arst_pc", pc, 0);
        chk("arst_valid", instr_valid, 0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h4000_0005;
        chk("rel_req", imem_req, 0);
        step();
        imem_ack = 1'b0;
        chk("late_req", imem_req, 1);
        chk("late_valid", instr_valid, 0);
        chk("late_addr", imem_addr, 0);
        step();
        chk("late_valid2", instr_valid, 0);
        chk_fields("late", 32'h0);
        fetch_one(32'h4000_0005, 1, 0, 32'd8);

`ifdef FETCH_TIMEOUT_EN
        pulses = 0;
        prev   = 0;
        for (int i = 0; i < 40; i++) begin
            chk("to_req", imem_req, 1);
            chk("to_addr", imem_addr, model_pc);
            if (fetch_err === 1'b1) begin
                pulses++;
                chk("to_single", prev, 0);
            end
            prev = (fetch_err === 1'b1) ? 1 : 0;
            step();
        end
        chk("to_pulse_seen", (pulses > 0) ? 1 : 0, 1);
        fetch_one(32'h0000_0000, 0, 0, 32'd12);
`else
        pulses = 0;
        prev   = pulses;
`endif

        fetch_one(32'hFC00_0000, 1, 1, 32'h0000_1234);
        for (int i = 0; i < 20; i++) begin
            imem_ack    = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            next_pc     = $urandom;
            step();
            chk("halt_req", imem_req, 0);
            chk("halt_valid", instr_valid, 0);
            chk("halt_hold", halted, 1);
            chk("halt_pc_hold", pc, model_pc);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have exactly one clock and its reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request; held until imem_ack.
REQ-005 imem_addr  output  32  read address, always equal to pc.
REQ-006 imem_ack  input  1  memory response strobe; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  32  instruction word.
REQ-008 next_pc  input  32  next PC from next_address (incr_pc), sampled on instruction accept.
REQ-009 pc  output  32  address of the currently held instruction.
REQ-010 instr_valid  output  1  decoded instruction fields are valid.
REQ-011 instr_ready  input  1  downstream accepts the instruction this cycle.
REQ-012 pc_sel  output  2  0 = sequential or branch, 1 = jump to label, 2 = jump to register.
REQ-013 brtype  output  3  branch condition code; 0 = not a branch.
REQ-014 branch_label  output  16  instr[15:0].
REQ-015 jmp_label  output  26  instr[25:0].
REQ-016 halted  output  1  HALT opcode reached.

Function
REQ-017 The FSM SHALL have four states: IDLE, FETCH, HOLD and HALT.
REQ-018 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-019 FETCH SHALL assert imem_req, keep imem_addr stable, and on imem_ack latch imem_rdata and go to HOLD (1-cycle latency from ack to instr_valid).
REQ-020 HOLD SHALL assert instr_valid; on instr_valid & instr_ready: pc <= next_pc, next state FETCH.
REQ-021 Decode SHALL be: opcode = instr[31:26]; 6'h10 -> pc_sel=1; 6'h11 -> pc_sel=2; 6'h19..6'h1F -> pc_sel=0, brtype=opcode[2:0]; all others -> pc_sel=0, brtype=0.
REQ-022 Opcode 6'h3F SHALL be presented in HOLD like any other instruction; when it is accepted the FSM SHALL go to HALT instead of FETCH, pc SHALL stay unchanged and halted SHALL be 1.
REQ-023 HALT SHALL be left only by reset; in HALT imem_req=0 and instr_valid=0.
REQ-024 pc SHALL take next_pc exactly, with no internal increment and 32-bit wrap (0xFFFFFFFC+4 is supplied as 0 by next_address).
REQ-025 instr_ready while instr_valid=0 SHALL be ignored; imem_ack outside FETCH SHALL be ignored.
REQ-026 Decoded outputs SHALL hold their values through HOLD while instr_ready=0.

Reset
REQ-027 Reset SHALL force: pc=0, state=IDLE, imem_req=0, instr_valid=0, pc_sel=0, brtype=0, branch_label=0, jmp_label=0, halted=0, latched instruction=0.
REQ-028 Reset asserted mid-FETCH or mid-HOLD SHALL abandon the transaction immediately; a late imem_ack after release SHALL be ignored because the FSM is in IDLE.

Configuration
REQ-029 With FETCH_TIMEOUT_EN defined, a 4-bit counter SHALL count FETCH cycles without ack; at 15 it SHALL pulse output fetch_err for 1 cycle and re-issue the request (counter cleared, imem_req stays 1).
REQ-030 Without FETCH_TIMEOUT_EN, the counter and the fetch_err port SHALL be absent and FETCH SHALL wait indefinitely.

Structure
REQ-031 A shared package SHALL hold the opcode constants (J, JR, branch base, HALT), the pc_sel encodings and the FSM state typedef.
REQ-032 Decode SHALL be a combinational sub-module instr_decode (instr in, pc_sel/brtype/labels out), instantiated once.

Verification
REQ-033 Reset release, memory acks after 2 cycles with 32'h0000_0000 -> imem_req rises 1 cycle after IDLE, imem_addr=0, instr_valid=1 one cycle after ack, pc_sel=0, brtype=0.
REQ-034 instr=32'h4000_001A (J), next_pc=26, instr_ready=1 -> pc_sel=1, jmp_label=26, next imem_addr=26.
REQ-035 instr=32'h6400_0047 (opcode 6'h19), instr_ready held 0 for 3 cycles -> brtype=1, branch_label=71 stable for all 3 cycles, pc unchanged until accept.
REQ-036 instr=32'hFC00_0000, accepted -> halted=1, imem_req stays 0 for 20 cycles, pc unchanged.
REQ-037 rst_n pulsed low during FETCH, ack arrives 1 cycle after release -> ignored, pc=0, fresh request issued from IDLE.
REQ-038 With FETCH_TIMEOUT_EN and no ack for 15 cycles -> fetch_err single-cycle pulse, imem_req continuously 1, imem_addr unchanged.
